// File: rtl/pixel_scan_sequencer.sv
// Purpose: scans N_PIX pixels through reset/integrate/sample-hold/single-slope conversion and streams codes.
// Latency: per pixel t_rst + t_int + t_sh + (code+1) + 1 cycles when downstream is always ready.
// Backpressure: OUT holds valid_o/data_o/idx_o/ovf_o until ready_i; abort_i or reset drops the result.
module pixel_scan_sequencer #(
  parameter  int N_PIX = 12,
  parameter  int CW    = 8,
  parameter  int TW    = 8,
  localparam int IW    = $clog2(N_PIX)
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             cont_i,
  input  logic [TW-1:0]    t_rst_i,
  input  logic [TW-1:0]    t_int_i,
  input  logic [TW-1:0]    t_sh_i,
  input  logic             cmp_i,
  input  logic             ready_i,
  output logic [N_PIX-1:0] pix_sel_o,
  output logic             sh_rst_o,
  output logic             sh_o,
  output logic             sh_cmp_o,
  output logic             ramp_en_o,
  output logic             counter_rst_o,
  output logic             valid_o,
  output logic [CW-1:0]    data_o,
  output logic [IW-1:0]    idx_o,
  output logic             ovf_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_INT, S_SH, S_CONV, S_OUT
  } state_t;

  localparam logic [CW-1:0] CODE_MAX = '1;
  localparam logic [IW-1:0] IDX_LAST = IW'(N_PIX - 1);

  state_t        state, state_nxt;
  logic          cmp_meta, cmp_s;
  logic          cont_q;
  logic [TW-1:0] t_rst_q, t_int_q, t_sh_q;
  logic [TW-1:0] ph_cnt;
  logic [TW-1:0] ph_last;
  logic          phase_done;
  logic [CW-1:0] count;
  logic [CW-1:0] data_q;
  logic          ovf_q;
  logic [IW-1:0] idx;
  logic          last_pix;

  // A zero length field behaves as a one-cycle phase, so the terminal count saturates at 0.
  function automatic logic [TW-1:0] last_cycle(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  // Select the terminal phase count for whichever timed phase is active.
  always_comb begin
    ph_last = '0;
    case (state)
      S_RST:   ph_last = last_cycle(t_rst_q);
      S_INT:   ph_last = last_cycle(t_int_q);
      S_SH:    ph_last = last_cycle(t_sh_q);
      default: ph_last = '0;
    endcase
  end

  assign phase_done = (ph_cnt == ph_last);
  assign last_pix   = (idx == IDX_LAST);

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) state <= S_IDLE;
    else            state <= state_nxt;
  end

  // Next-state logic; abort overrides every other transition, including a handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start_i)    state_nxt = S_RST;
      S_RST:  if (phase_done) state_nxt = S_INT;
      S_INT:  if (phase_done) state_nxt = S_SH;
      S_SH:   if (phase_done) state_nxt = S_CONV;
      S_CONV: if (cmp_s || count == CODE_MAX) state_nxt = S_OUT;
      S_OUT:  if (ready_i) state_nxt = (last_pix && !cont_q) ? S_IDLE : S_RST;
      default: state_nxt = S_IDLE;
    endcase
    if (abort_i) state_nxt = S_IDLE;
  end

  // Comparator synchroniser, configuration latch, phase/conversion counters and result capture.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      cmp_meta <= 1'b0;
      cmp_s    <= 1'b0;
      cont_q   <= 1'b0;
      t_rst_q  <= '0;
      t_int_q  <= '0;
      t_sh_q   <= '0;
      ph_cnt   <= '0;
      count    <= '0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
      idx      <= '0;
    end else begin
      cmp_meta <= cmp_i;
      cmp_s    <= cmp_meta;
      if (abort_i) begin
        ph_cnt <= '0;
        count  <= '0;
        data_q <= '0;
        ovf_q  <= 1'b0;
        idx    <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_i) begin
              cont_q  <= cont_i;
              t_rst_q <= t_rst_i;
              t_int_q <= t_int_i;
              t_sh_q  <= t_sh_i;
              idx     <= '0;
              ph_cnt  <= '0;
              count   <= '0;
            end
          end
          S_RST, S_INT, S_SH: begin
            ph_cnt <= phase_done ? '0 : ph_cnt + TW'(1);
            count  <= '0;
          end
          S_CONV: begin
            // A comparator trip wins over saturation when both happen together.
            if (cmp_s) begin
              data_q <= count;
              ovf_q  <= 1'b0;
            end else if (count == CODE_MAX) begin
              data_q <= CODE_MAX;
              ovf_q  <= 1'b1;
            end else begin
              count <= count + CW'(1);
            end
          end
          S_OUT: begin
            if (ready_i) begin
              ph_cnt <= '0;
              idx    <= last_pix ? '0 : idx + IW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Analog switch controls and stream outputs decoded from the state; all zero in IDLE.
  always_comb begin
    busy_o        = (state != S_IDLE);
    sh_rst_o      = (state == S_RST);
    sh_o          = (state == S_SH);
    sh_cmp_o      = (state == S_CONV);
    ramp_en_o     = (state == S_CONV);
    counter_rst_o = (state == S_CONV) && (count == '0);
    valid_o       = (state == S_OUT);
    data_o        = (state == S_OUT) ? data_q : '0;
    idx_o         = (state == S_OUT) ? idx : '0;
    ovf_o         = (state == S_OUT) && ovf_q;
    done_o        = (state == S_OUT) && ready_i && last_pix && !abort_i;
    pix_sel_o     = (state != S_IDLE) ? (N_PIX'(1) << idx) : '0;
  end

endmodule

// File: tb/tb_pixel_scan_sequencer.sv
// Bench for pixel_scan_sequencer: table of single-shot scan vectors plus hand-written
// reset, backpressure and continuous/abort sequences. Results are checked against a
// queue of expected {idx, code, ovf} records pushed when each scan is launched.
module tb_pixel_scan_sequencer;

  localparam int N_PIX = 12;
  localparam int CW    = 8;
  localparam int TW    = 8;
  localparam int IW    = $clog2(N_PIX);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start_i, abort_i, cont_i, cmp_i, ready_i;
  logic [TW-1:0]    t_rst_i, t_int_i, t_sh_i;
  logic [N_PIX-1:0] pix_sel_o;
  logic             sh_rst_o, sh_o, sh_cmp_o, ramp_en_o, counter_rst_o;
  logic             valid_o, ovf_o, busy_o, done_o;
  logic [CW-1:0]    data_o;
  logic [IW-1:0]    idx_o;

  pixel_scan_sequencer #(.N_PIX(N_PIX), .CW(CW), .TW(TW)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start_i), .abort_i(abort_i),
    .cont_i(cont_i), .t_rst_i(t_rst_i), .t_int_i(t_int_i), .t_sh_i(t_sh_i),
    .cmp_i(cmp_i), .ready_i(ready_i), .pix_sel_o(pix_sel_o), .sh_rst_o(sh_rst_o),
    .sh_o(sh_o), .sh_cmp_o(sh_cmp_o), .ramp_en_o(ramp_en_o),
    .counter_rst_o(counter_rst_o), .valid_o(valid_o), .data_o(data_o),
    .idx_o(idx_o), .ovf_o(ovf_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] tr, ti, ts;
    int         mode;   // 0: cmp low, 1: cmp high, 2: cmp rises at CONV cycle 'rise'
    int         rise;
    int         code;
    bit         ovf;
  } vec_t;

  typedef struct {
    int idx;
    int data;
    int ovf;
  } exp_t;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  exp_t e;
  int   cmp_mode = 0;
  int   rise_at  = 0;
  int   conv_cyc = 0;
  int   busy_cnt = 0;
  int   shrst_cnt = 0;
  int   done_cnt = 0;
  int   cr_cnt   = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int plen(input int t);
    return (t == 0) ? 1 : t;
  endfunction

  // Monitor (scoreboard pop, activity counters) then comparator stimulus, away from the active edge.
  always @(negedge clk) begin
    if (busy_o) busy_cnt++;
    if (sh_rst_o) shrst_cnt++;
    if (done_o) done_cnt++;
    if (counter_rst_o) cr_cnt++;
    if (valid_o && ready_i && !abort_i) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("result_idx", int'(idx_o), e.idx);
        check("result_data", int'(data_o), e.data);
        check("result_ovf", int'(ovf_o), e.ovf);
      end
    end
    if (cmp_mode == 1) begin
      cmp_i = 1'b1;
    end else if (cmp_mode == 2) begin
      if (ramp_en_o) begin
        conv_cyc++;
        if (conv_cyc == rise_at) cmp_i = 1'b1;
      end else begin
        conv_cyc = 0;
        cmp_i = 1'b0;
      end
    end else begin
      cmp_i = 1'b0;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; ready_i = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    exp_q.delete();
    busy_cnt = 0; shrst_cnt = 0; done_cnt = 0; cr_cnt = 0;
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int cyc, per;
    do_reset();
    cmp_mode = v.mode; rise_at = v.rise;
    cont_i = 1'b0; t_rst_i = v.tr; t_int_i = v.ti; t_sh_i = v.ts;
    for (int i = 0; i < N_PIX; i++) exp_q.push_back('{i, v.code, int'(v.ovf)});
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    cyc = 0;
    while (busy_o && cyc < 20000) begin
      tick();
      cyc++;
    end
    check($sformatf("v%0d_timeout", n), int'(cyc < 20000), 1);
    per = plen(v.tr) + plen(v.ti) + plen(v.ts) + (v.code + 1) + 1;
    check($sformatf("v%0d_busy_cycles", n), busy_cnt, N_PIX * per);
    check($sformatf("v%0d_sh_rst_cycles", n), shrst_cnt, N_PIX * plen(v.tr));
    check($sformatf("v%0d_counter_rst", n), cr_cnt, N_PIX);
    check($sformatf("v%0d_done_pulses", n), done_cnt, 1);
    check($sformatf("v%0d_results_left", n), exp_q.size(), 0);
    check($sformatf("v%0d_idle_pix_sel", n), int'(pix_sel_o), 0);
  endtask

  vec_t vecs[4];
  int   n;

  initial begin
    // Codes in mode 2: cmp_i rises during CONV cycle 'rise' (1-based), the two-flop
    // synchroniser makes it visible two cycles later, so the captured count is rise+1.
    vecs[0] = '{8'd2, 8'd3, 8'd1, 2, 2, 3, 1'b0};
    vecs[1] = '{8'd0, 8'd0, 8'd0, 1, 0, 0, 1'b0};
    vecs[2] = '{8'd1, 8'd1, 8'd1, 0, 0, 255, 1'b1};
    vecs[3] = '{8'd4, 8'd0, 8'd7, 2, 5, 6, 1'b0};

    rst_n = 1'b0; start_i = 1'b1; abort_i = 1'b0; cont_i = 1'b0; ready_i = 1'b1;
    t_rst_i = '0; t_int_i = '0; t_sh_i = '0; cmp_i = 1'b0;

    // Reset held with start_i asserted: everything stays quiet.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_busy", int'(busy_o), 0);
      check("rst_outputs_or", int'(|{pix_sel_o, sh_rst_o, sh_o, sh_cmp_o, ramp_en_o,
                                     counter_rst_o, valid_o, data_o, idx_o, ovf_o, done_o}), 0);
    end
    rst_n = 1'b1;
    tick();
    check("rst_release_busy", int'(busy_o), 1);
    check("rst_release_sh_rst", int'(sh_rst_o), 1);
    check("rst_release_pix_sel", int'(pix_sel_o), 1);
    start_i = 1'b0;
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("abort_from_rst_busy", int'(busy_o), 0);

    // Table-driven single-shot scans.
    for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

    // Backpressure: hold ready low for 10 OUT cycles.
    do_reset();
    cmp_mode = 2; rise_at = 4; cont_i = 1'b0;
    t_rst_i = 8'd1; t_int_i = 8'd1; t_sh_i = 8'd1;
    ready_i = 1'b0;
    exp_q.push_back('{0, 5, 0});
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    n = 0;
    while (!valid_o && n < 100) begin
      tick();
      n++;
    end
    check("bp_valid_timeout", int'(n < 100), 1);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid_held", int'(valid_o), 1);
      check("bp_data_held", int'(data_o), 5);
      check("bp_idx_held", int'(idx_o), 0);
      tick();
    end
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    check("bp_next_rst", int'(sh_rst_o), 1);
    check("bp_next_pix_sel", int'(pix_sel_o), 2);
    check("bp_valid_dropped", int'(valid_o), 0);
    check("bp_results_left", exp_q.size(), 0);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    ready_i = 1'b1;

    // Continuous mode: two full scans, then abort during CONV of pixel 5.
    do_reset();
    cmp_mode = 1; cont_i = 1'b1;
    t_rst_i = 8'd0; t_int_i = 8'd0; t_sh_i = 8'd0;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < N_PIX; i++) exp_q.push_back('{i, 0, 0});
    for (int i = 0; i < 5; i++) exp_q.push_back('{i, 0, 0});
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    cont_i = 1'b0;
    for (int s = 0; s < 2; s++) begin
      n = 0;
      while (!done_o && n < 200) begin
        tick();
        n++;
      end
      check("cont_done_timeout", int'(n < 200), 1);
      tick();
      check("cont_wrap_pix_sel", int'(pix_sel_o), 1);
      check("cont_wrap_sh_rst", int'(sh_rst_o), 1);
    end
    n = 0;
    while (!(ramp_en_o && pix_sel_o[5]) && n < 200) begin
      tick();
      n++;
    end
    check("cont_conv5_timeout", int'(n < 200), 1);
    abort_i = 1'b1;
    start_i = 1'b1;
    tick();
    abort_i = 1'b0;
    start_i = 1'b0;
    check("abort_busy", int'(busy_o), 0);
    check("abort_valid", int'(valid_o), 0);
    check("abort_pix_sel", int'(pix_sel_o), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("abort_stays_idle", int'(busy_o), 0);
    end
    check("cont_done_pulses", done_cnt, 2);
    check("cont_results_left", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
